q3_vector_sequencer: RTL and testbench
======================================

# q3_vector_sequencer

Exhaustive test-vector controller for the team's 4-input transistor-level NAND/NOT network (inputs a,b,c,d; output w). On a start request it drives all 16 input combinations in ascending order, holds each one for a programmable settle window so the switch-level propagation delays resolve, samples w, and compares it against a stored truth table. It sits between the lab bench or top-level harness and the gate-level circuit, and reports pass/fail, the error count and the first failing vector.

## Interface
- SETTLE_CYC, default 4: clock cycles each vector is held before w is sampled. Must be ≥1; 0 is an elaboration error.
- EXPECT, default 16'h1BBB: expected w for each vector. Bit i is the expected w for input index i, where i = {a,b,c,d} and a is the MSB.
- clk  in  1  single rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; honoured only in IDLE.
- abort  in  1  cancel a run in progress.
- dut_in  out  4  {a,b,c,d} driven to the circuit; registered.
- dut_w  in  1  circuit output w.
- vec_idx  out  4  index of the vector currently applied.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse at the end of a completed run.
- pass  out  1  1 when the last completed run had err_cnt==0; valid from done onward.
- err_cnt  out  5  number of mismatches in the current or last run (0..16).
- first_err_valid  out  1  at least one mismatch has been seen this run.
- first_err_idx  out  4  index of the first mismatching vector.

## Operation
- States:
  - IDLE: waiting for start.
  - SETTLE: holding a vector while the settle timer counts down.
  - SAMPLE: one cycle in which dut_w is compared with EXPECT[vec_idx].
  - DONE: one cycle with done=1.
- IDLE & start → SETTLE:
  - vec_idx=0, dut_in=0.
  - Clear err_cnt, first_err_valid, first_err_idx and pass.
  - Load the settle timer with SETTLE_CYC-1.
- SETTLE:
  - Timer decrements each cycle.
  - Timer==0 → SAMPLE.
- SAMPLE:
  - Mismatch means dut_w != EXPECT[vec_idx]. X or Z on dut_w counts as a mismatch in simulation.
  - On mismatch: err_cnt+1. If first_err_valid==0, latch first_err_idx=vec_idx and set first_err_valid.
  - If vec_idx==15 → DONE.
  - Otherwise vec_idx+1, dut_in=vec_idx+1, reload the timer, → SETTLE.
- DONE:
  - done=1 and pass=(final err_cnt==0).
  - Next state is IDLE.
- err_cnt never overflows: its maximum is 16, which fits in 5 bits.
- abort while busy:
  - Next edge → IDLE, dut_in=0, vec_idx=0.
  - No done pulse; pass=0.
  - err_cnt and first_err_* keep their partial values.
- abort in IDLE or DONE: ignored.
- start while busy or in DONE: ignored; there is no queuing.
- start and abort in the same cycle in IDLE: start wins.
- Reset values, applied immediately on rst_n low:
  - state=IDLE
  - dut_in=0, vec_idx=0
  - busy=0, done=0, pass=0
  - err_cnt=0, first_err_valid=0, first_err_idx=0
- Reset mid-run: the run is lost and all outputs return to their reset values.

## Timing
- Edge 0 is the edge that samples start. dut_in=0 from edge 0.
- Each vector occupies SETTLE_CYC+1 cycles: SETTLE_CYC in SETTLE plus 1 in SAMPLE.
- dut_w is sampled at the end of cycle k·(SETTLE_CYC+1)+SETTLE_CYC for vector k.
- done is high in the cycle after edge 16·(SETTLE_CYC+1). With the default this is edge 80, so a run takes 81 cycles including DONE.
- busy rises at edge 0 and falls at edge 16·(SETTLE_CYC+1).
- err_cnt updates on the edge that ends SAMPLE.
- All outputs are registered. dut_w passes through no synchronizer: the circuit is driven from this block's flops on the same clock.
- The clock period × SETTLE_CYC must exceed the circuit's worst-case switch-level delay. The bench clock is 10 ns with SETTLE_CYC=4.

## Structure
- Package q3_seq_pkg holds:
  - state enum: IDLE, SETTLE, SAMPLE, DONE
  - VEC_W=4
  - NUM_VEC=16
  - Q3_EXPECT=16'h1BBB
- One sub-module, settle_timer:
  - loadable down-counter, width $clog2(SETTLE_CYC+1)
  - inputs: load, load value, enable
  - output: zero flag
- The FSM, compare logic and error bookkeeping stay in q3_vector_sequencer.

## Test plan
- Real gate-level circuit, SETTLE_CYC=4, 10 ns clock, start pulse → done at cycle 81, pass=1, err_cnt=0, first_err_valid=0.
- dut_w stuck at 0 → err_cnt=10, first_err_idx=0, pass=0.
- dut_w stuck at 1 → err_cnt=6, first_err_idx=2, pass=0.
- abort asserted 20 cycles after start → busy low and dut_in=0 one edge later, no done pulse, err_cnt holds its partial value.
- start re-pulsed mid-run and in the DONE cycle → ignored; exactly one done pulse per accepted start.
- rst_n low mid-run (asynchronous, between edges) → all outputs at reset values immediately; a new start after release gives a full clean run with pass=1.

Source files
------------

// File: rtl/q3_seq_pkg.sv
// ---------------------------------------------------------------------------
// q3_seq_pkg
// Shared types and constants for the q3 exhaustive test-vector sequencer.
// The sequencer walks every input combination of the 4-input NAND/NOT
// network and checks its output w against a stored truth table.
//
// Contents:
//   state_t   - sequencer FSM states
//   VEC_W     - width of one input vector {a,b,c,d}
//   NUM_VEC   - number of vectors in an exhaustive run
//   ERR_W     - width of the error counter (must hold NUM_VEC itself)
//   Q3_EXPECT - reference truth table, bit i = expected w for vector i
// ---------------------------------------------------------------------------
package q3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;

    // The counter must reach NUM_VEC (every vector failing), hence the +1.
    localparam int ERR_W   = $clog2(NUM_VEC + 1);

    localparam logic [NUM_VEC-1:0] Q3_EXPECT = 16'h1BBB;

endpackage : q3_seq_pkg

// File: rtl/q3_vector_sequencer_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Loadable down-counter that measures how long a test vector has been held.
// It stops at zero rather than wrapping, so the zero flag stays asserted
// until the next load.
//
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset (count -> 0)
//   load      in  1  load count with load_val (has priority over en)
//   load_val  in  W  value to load
//   en        in  1  decrement enable
//   zero      out 1  count is zero
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the counter saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule : settle_timer

// File: rtl/q3_vector_sequencer.sv
// ---------------------------------------------------------------------------
// q3_vector_sequencer
// Exhaustive test-vector controller for the 4-input NAND/NOT network.
// On start it applies all 16 input combinations in ascending order, holds
// each for SETTLE_CYC cycles so the switch-level delays resolve, samples w
// for one cycle and compares it with EXPECT. It reports the error count,
// the first failing vector and an overall pass flag.
//
// Parameters:
//   SETTLE_CYC  cycles each vector is held before sampling (>= 1)
//   EXPECT      expected w per vector, bit i for vector i = {a,b,c,d}
//
// Ports:
//   clk              in  1  rising-edge clock
//   rst_n            in  1  asynchronous active-low reset
//   start            in  1  begin a run (honoured only in IDLE)
//   abort            in  1  cancel a run in progress
//   dut_in           out 4  {a,b,c,d} driven to the circuit
//   dut_w            in  1  circuit output w
//   vec_idx          out 4  index of the vector currently applied
//   busy             out 1  high while settling or sampling
//   done             out 1  one-cycle pulse at the end of a completed run
//   pass             out 1  last completed run had no mismatches
//   err_cnt          out 5  mismatches in the current or last run
//   first_err_valid  out 1  at least one mismatch seen this run
//   first_err_idx    out 4  index of the first mismatching vector
// ---------------------------------------------------------------------------
module q3_vector_sequencer
    import q3_seq_pkg::*;
#(
    parameter int                 SETTLE_CYC = 4,
    parameter logic [NUM_VEC-1:0] EXPECT     = Q3_EXPECT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_w,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_idx
);

    // A zero-length settle window would sample before the vector is applied.
    generate
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("q3_vector_sequencer: SETTLE_CYC must be at least 1");
        end
    endgenerate

    // Guarded so an illegal SETTLE_CYC still yields a legal width while the
    // elaboration error above is reported.
    localparam int TW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0] RELOAD = TW'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_next;
    logic             timer_load;
    logic             timer_en;
    logic             timer_zero;
    logic             mismatch;
    logic [ERR_W-1:0] err_after;

    // -----------------------------------------------------------------------
    // Settle timer
    // -----------------------------------------------------------------------
    settle_timer #(
        .W(TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (RELOAD),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // -----------------------------------------------------------------------
    // Compare
    // -----------------------------------------------------------------------
    // The case-equality makes X/Z on dut_w count as a mismatch in simulation;
    // synthesis treats it as an ordinary equality.
    assign mismatch  = (dut_w === EXPECT[vec_idx]) ? 1'b0 : 1'b1;
    assign err_after = err_cnt + {{(ERR_W-1){1'b0}}, mismatch};

    // dut_in is the vector register itself, so it is flop-driven.
    assign dut_in = vec_idx;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and timer control
    // -----------------------------------------------------------------------
    // Abort is only honoured in SETTLE and SAMPLE; start only in IDLE, so a
    // simultaneous start+abort in IDLE naturally lets start win.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (timer_zero) begin
                    state_next = SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (vec_idx == LAST_VEC) begin
                    state_next = DONE;
                end else begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Status outputs, registered from the next state so they line up with it
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SETTLE) || (state_next == SAMPLE);
            done <= (state_next == DONE);
        end
    end

    // -----------------------------------------------------------------------
    // Vector index and error bookkeeping
    // -----------------------------------------------------------------------
    // An abort that lands on a SAMPLE cycle discards that sample: the run is
    // being cancelled, so the partial results stop at the previous vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx         <= '0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_idx         <= '0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        first_err_idx   <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        vec_idx <= '0;
                        pass    <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        vec_idx <= '0;
                        pass    <= 1'b0;
                    end else begin
                        err_cnt <= err_after;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_idx   <= vec_idx;
                        end
                        if (vec_idx == LAST_VEC) begin
                            pass <= (err_after == '0);
                        end else begin
                            vec_idx <= vec_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : q3_vector_sequencer

// File: tb/tb_q3_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_q3_vector_sequencer
// Self-checking bench for q3_vector_sequencer. The circuit under test is
// modelled as a truth table with a propagation delay; the reference model
// predicts every output per cycle from the run timeline (vector k occupies
// cycles k*(S+1) .. k*(S+1)+S) and from popcounts over the mismatch mask.
// ---------------------------------------------------------------------------
module tb_q3_vector_sequencer;
    import q3_seq_pkg::*;

    localparam int          S   = 4;
    localparam int          T   = S + 1;
    localparam int          L   = 16 * T;
    localparam logic [15:0] EXP = 16'h1BBB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic        dut_w;
    logic [3:0]  vec_idx;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic        first_err_valid;
    logic [3:0]  first_err_idx;

    logic [15:0] circ_tt;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cyc          = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    // Behavioural stand-in for the gate network: table lookup with a
    // propagation delay shorter than the settle window.
    assign #3 dut_w = circ_tt[dut_in];

    q3_vector_sequencer #(
        .SETTLE_CYC (S),
        .EXPECT     (EXP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .dut_in          (dut_in),
        .dut_w           (dut_w),
        .vec_idx         (vec_idx),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx)
    );

    // Number of mismatching vectors among the first n vectors of a run.
    function automatic int errsBefore(input logic [15:0] tt, input int n);
        logic [15:0] m;
        int          e;
        m = tt ^ EXP;
        e = 0;
        for (int k = 0; k < n && k < 16; k++) begin
            if (m[k]) e++;
        end
        return e;
    endfunction

    // Lowest mismatching vector among the first n, or -1 if none.
    function automatic int firstBad(input logic [15:0] tt, input int n);
        logic [15:0] m;
        m = tt ^ EXP;
        for (int k = 0; k < n && k < 16; k++) begin
            if (m[k]) return k;
        end
        return -1;
    endfunction

    // Single comparison point: counts the test and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Checks every output against the reset values.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, " dut_in"}, 32'(dut_in), 0);
        checkOutput({tag, " vec_idx"}, 32'(vec_idx), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
        checkOutput({tag, " pass"}, 32'(pass), 0);
        checkOutput({tag, " err_cnt"}, 32'(err_cnt), 0);
        checkOutput({tag, " fe_valid"}, 32'(first_err_valid), 0);
        checkOutput({tag, " fe_idx"}, 32'(first_err_idx), 0);
    endtask

    // One run: pulse start, then check all outputs every cycle against the
    // model. abort_cyc/restart_cyc of -1 disable that event; a restart pulse
    // is also always given in the DONE cycle of a completed run.
    task automatic applyStimulus(input logic [15:0] tt, input int abort_cyc,
                                 input int restart_cyc, input bit abort_with_start);
        int n;
        int fb;
        int total;
        circ_tt = tt;
        total   = errsBefore(tt, 16);
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk);
        for (int c = 0; c <= L + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            cyc   = c;
            if (abort_cyc >= 0 && c > abort_cyc) begin
                n  = abort_cyc / T;
                fb = firstBad(tt, n);
                checkOutput("abort busy", 32'(busy), 0);
                checkOutput("abort done", 32'(done), 0);
                checkOutput("abort dut_in", 32'(dut_in), 0);
                checkOutput("abort vec_idx", 32'(vec_idx), 0);
                checkOutput("abort pass", 32'(pass), 0);
                checkOutput("abort err_cnt", 32'(err_cnt), 32'(errsBefore(tt, n)));
                checkOutput("abort fe_valid", 32'(first_err_valid), 32'(fb >= 0));
                checkOutput("abort fe_idx", 32'(first_err_idx), 32'((fb >= 0) ? fb : 0));
                if (c >= abort_cyc + 3) break;
            end else begin
                n  = (c / T > 16) ? 16 : c / T;
                fb = firstBad(tt, n);
                checkOutput("busy", 32'(busy), 32'(c < L));
                checkOutput("done", 32'(done), 32'(c == L));
                checkOutput("dut_in", 32'(dut_in), 32'((c < L) ? c / T : 15));
                checkOutput("vec_idx", 32'(vec_idx), 32'((c < L) ? c / T : 15));
                checkOutput("pass", 32'(pass), 32'((c >= L) && (total == 0)));
                checkOutput("err_cnt", 32'(err_cnt), 32'(errsBefore(tt, n)));
                checkOutput("fe_valid", 32'(first_err_valid), 32'(fb >= 0));
                checkOutput("fe_idx", 32'(first_err_idx), 32'((fb >= 0) ? fb : 0));
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == restart_cyc && (abort_cyc < 0 || c < abort_cyc)) start = 1'b1;
            if (c == L && abort_cyc < 0) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Picks a random abort cycle that falls in a SETTLE cycle of the run.
    function automatic int randomAbortCycle();
        int a;
        a = $urandom_range(0, L - 1);
        if (a % T == T - 1) a--;
        return a;
    endfunction

    // Main sequence: reset, directed runs, random runs, async reset mid-run.
    initial begin
        logic [15:0] tt;
        int          a;
        int          r;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        circ_tt = EXP;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(EXP, -1, -1, 1'b0);
        applyStimulus(16'h0000, -1, 37, 1'b0);
        applyStimulus(16'hFFFF, -1, 12, 1'b1);
        applyStimulus(EXP, 20, -1, 1'b0);
        applyStimulus(16'h0000, 20, 7, 1'b0);

        for (int i = 0; i < 6; i++) begin
            tt = 16'($urandom);
            if ($urandom_range(0, 1) == 1) tt = EXP ^ (16'h1 << $urandom_range(0, 15));
            a = ($urandom_range(0, 1) == 1) ? randomAbortCycle() : -1;
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, L - 1)) : -1;
            applyStimulus(tt, a, r, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges in the middle of a faulty run.
        circ_tt = 16'h0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cyc = -1;
        checkResetValues("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("after reset");
        applyStimulus(EXP, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_q3_vector_sequencer
